// File: rtl/control_pipe_pkg.sv
// ============================================================================
// Module      : ctrl_pkg
// Description : Control bundle types and bubble constants for control_pipe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ctrl_pkg;

    localparam logic [1:0] RESULT_LOAD = 2'b01;

    typedef struct packed {
        logic       valid;
        logic [1:0] result_src;
        logic [1:0] mem_write;
        logic       alu_src;
        logic [2:0] reg_write;
        logic [2:0] alu_control;
        logic       jump;
        logic       branch;
        logic [2:0] funct3;
    } ctrl_e_t;

    typedef struct packed {
        logic       valid;
        logic [1:0] result_src;
        logic [1:0] mem_write;
        logic [2:0] reg_write;
        logic [2:0] funct3;
    } ctrl_m_t;

    typedef struct packed {
        logic       valid;
        logic [1:0] result_src;
        logic [2:0] reg_write;
    } ctrl_w_t;

    localparam ctrl_e_t CTRL_E_BUBBLE = '0;
    localparam ctrl_m_t CTRL_M_BUBBLE = '0;
    localparam ctrl_w_t CTRL_W_BUBBLE = '0;

endpackage

`default_nettype wire

// File: rtl/control_pipe_stage_reg.sv
// ============================================================================
// Module      : ctrl_stage_reg
// Description : Type-parameterized stage register; bubble beats hold.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ctrl_stage_reg #(
    parameter type T      = logic,
    parameter T    BUBBLE = T'(0)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic hold,
    input  logic bubble,
    input  T     d,
    output T     q
);

    T r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= BUBBLE;
        end else if (bubble) begin
            r_q <= BUBBLE;
        end else if (!hold) begin
            r_q <= d;
        end
    end

    assign q = r_q;

endmodule

`default_nettype wire

// File: rtl/control_pipe.sv
// ============================================================================
// Module      : control_pipe
// Description : E/M/W control pipeline with load-use/redirect hazard handling
//               and retired-instruction counter. Optional data-memory stall
//               support is enabled by defining CTRL_PIPE_MEMSTALL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module control_pipe
    import ctrl_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int INSTRET_WIDTH  = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      valid_d,
    input  logic [1:0]                ResultSrcD,
    input  logic [1:0]                MemWriteD,
    input  logic                      ALUSrcD,
    input  logic [2:0]                RegWriteD,
    input  logic [2:0]                ALUControlD,
    input  logic                      JumpD,
    input  logic                      BranchD,
    input  logic [2:0]                funct3D,
    input  logic [REG_ADDR_WIDTH-1:0] rdD,
    input  logic [REG_ADDR_WIDTH-1:0] rs1D,
    input  logic [REG_ADDR_WIDTH-1:0] rs2D,
    input  logic                      take_branch_e,
`ifdef CTRL_PIPE_MEMSTALL_EN
    input  logic                      stall_m,
`endif
    output logic [2:0]                ALUControlE,
    output logic                      ALUSrcE,
    output logic [2:0]                funct3E,
    output logic [REG_ADDR_WIDTH-1:0] rdE,
    output logic                      valid_e,
    output logic                      PCSrcE,
    output logic [1:0]                MemWriteM,
    output logic [1:0]                ResultSrcM,
    output logic [2:0]                RegWriteM,
    output logic [2:0]                funct3M,
    output logic [REG_ADDR_WIDTH-1:0] rdM,
    output logic [1:0]                ResultSrcW,
    output logic [2:0]                RegWriteW,
    output logic [REG_ADDR_WIDTH-1:0] rdW,
    output logic                      valid_w,
    output logic                      stall_d,
    output logic                      flush_d,
    output logic [INSTRET_WIDTH-1:0]  instret
);

    typedef struct packed { ctrl_e_t c; logic [REG_ADDR_WIDTH-1:0] rd; } stage_e_t;
    typedef struct packed { ctrl_m_t c; logic [REG_ADDR_WIDTH-1:0] rd; } stage_m_t;
    typedef struct packed { ctrl_w_t c; logic [REG_ADDR_WIDTH-1:0] rd; } stage_w_t;

    localparam stage_e_t C_E_BUBBLE = '{c: CTRL_E_BUBBLE, rd: '0};
    localparam stage_m_t C_M_BUBBLE = '{c: CTRL_M_BUBBLE, rd: '0};
    localparam stage_w_t C_W_BUBBLE = '{c: CTRL_W_BUBBLE, rd: '0};

    stage_e_t r_e, w_d_bundle;
    stage_m_t r_m, w_m_next;
    stage_w_t r_w, w_w_next;
    logic     w_stall_m, w_lu, w_redirect, w_pcsrc;
    logic [INSTRET_WIDTH-1:0] r_instret;

`ifdef CTRL_PIPE_MEMSTALL_EN
    assign w_stall_m = stall_m;
`else
    assign w_stall_m = 1'b0;
`endif

    assign w_lu = r_e.c.valid && (r_e.c.result_src == RESULT_LOAD) && (r_e.rd != '0)
                  && valid_d && ((r_e.rd == rs1D) || (r_e.rd == rs2D));
    assign w_redirect = r_e.c.valid && (r_e.c.jump || (r_e.c.branch && take_branch_e));
    // A memory stall freezes E, so a pending redirect waits until it clears.
    assign w_pcsrc = w_redirect && !w_stall_m;

    assign PCSrcE  = w_pcsrc;
    assign flush_d = w_pcsrc;
    assign stall_d = (w_lu && !w_redirect) || w_stall_m;

    always_comb begin
        w_d_bundle = C_E_BUBBLE;
        if (valid_d) begin
            w_d_bundle.c.valid       = 1'b1;
            w_d_bundle.c.result_src  = ResultSrcD;
            w_d_bundle.c.mem_write   = MemWriteD;
            w_d_bundle.c.alu_src     = ALUSrcD;
            w_d_bundle.c.reg_write   = RegWriteD;
            w_d_bundle.c.alu_control = ALUControlD;
            w_d_bundle.c.jump        = JumpD;
            w_d_bundle.c.branch      = BranchD;
            w_d_bundle.c.funct3      = funct3D;
            w_d_bundle.rd            = rdD;
        end
    end

    always_comb begin
        w_m_next              = C_M_BUBBLE;
        w_m_next.c.valid      = r_e.c.valid;
        w_m_next.c.result_src = r_e.c.result_src;
        w_m_next.c.mem_write  = r_e.c.mem_write;
        w_m_next.c.reg_write  = r_e.c.reg_write;
        w_m_next.c.funct3     = r_e.c.funct3;
        w_m_next.rd           = r_e.rd;
    end

    always_comb begin
        w_w_next              = C_W_BUBBLE;
        w_w_next.c.valid      = r_m.c.valid;
        w_w_next.c.result_src = r_m.c.result_src;
        w_w_next.c.reg_write  = r_m.c.reg_write;
        w_w_next.rd           = r_m.rd;
    end

    ctrl_stage_reg #(.T(stage_e_t), .BUBBLE(C_E_BUBBLE)) u_stage_e (
        .clk    (clk),
        .rst_n  (rst_n),
        .hold   (w_stall_m),
        .bubble (w_pcsrc || (w_lu && !w_stall_m)),
        .d      (w_d_bundle),
        .q      (r_e)
    );

    ctrl_stage_reg #(.T(stage_m_t), .BUBBLE(C_M_BUBBLE)) u_stage_m (
        .clk    (clk),
        .rst_n  (rst_n),
        .hold   (w_stall_m),
        .bubble (1'b0),
        .d      (w_m_next),
        .q      (r_m)
    );

    ctrl_stage_reg #(.T(stage_w_t), .BUBBLE(C_W_BUBBLE)) u_stage_w (
        .clk    (clk),
        .rst_n  (rst_n),
        .hold   (1'b0),
        .bubble (w_stall_m),
        .d      (w_w_next),
        .q      (r_w)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instret <= '0;
        end else if (r_w.c.valid) begin
            r_instret <= r_instret + INSTRET_WIDTH'(1);
        end
    end

    assign ALUControlE = r_e.c.alu_control;
    assign ALUSrcE     = r_e.c.alu_src;
    assign funct3E     = r_e.c.funct3;
    assign rdE         = r_e.rd;
    assign valid_e     = r_e.c.valid;
    assign MemWriteM   = r_m.c.mem_write;
    assign ResultSrcM  = r_m.c.result_src;
    assign RegWriteM   = r_m.c.reg_write;
    assign funct3M     = r_m.c.funct3;
    assign rdM         = r_m.rd;
    assign ResultSrcW  = r_w.c.result_src;
    assign RegWriteW   = r_w.c.reg_write;
    assign rdW         = r_w.rd;
    assign valid_w     = r_w.c.valid;
    assign instret     = r_instret;

endmodule

`default_nettype wire

// File: doc/control_pipe.md
# control_pipe

Control-signal pipeline that sits directly downstream of the decode-stage control unit in the 5-stage core. It accepts the D-stage control bundle and carries it through the E, M and W stage registers, inserting bubbles where needed. It detects load-use hazards and taken branches/jumps, and generates the matching stall/flush requests for the fetch/decode registers. It also counts retired instructions.

## Interface
- REG_ADDR_WIDTH, 5, register-index width
- INSTRET_WIDTH, 32, retired-instruction counter width

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- valid_d  in  1  D stage holds a real instruction
- ResultSrcD  in  2  result select (2'b01 = load data)
- MemWriteD  in  2  store size/enable
- ALUSrcD  in  1  ALU operand B select
- RegWriteD  in  3  register write enable/mode (0 = no write)
- ALUControlD  in  3  ALU operation
- JumpD, BranchD  in  1 each  jump / conditional branch
- funct3D  in  3  carried for branch compare and load/store sizing
- rdD, rs1D, rs2D  in  REG_ADDR_WIDTH  destination / source register indices
- take_branch_e  in  1  E-stage branch comparison result
- stall_m  in  1  data-memory wait; present only with CTRL_PIPE_MEMSTALL_EN
- ALUControlE, ALUSrcE, funct3E, rdE, valid_e  out  3/1/3/REG_ADDR_WIDTH/1  E-stage register
- PCSrcE  out  1  redirect PC to branch/jump target
- MemWriteM, ResultSrcM, RegWriteM, funct3M, rdM  out  2/2/3/3/REG_ADDR_WIDTH  M-stage register
- ResultSrcW, RegWriteW, rdW, valid_w  out  2/3/REG_ADDR_WIDTH/1  W-stage register
- stall_d  out  1  hold the F and D registers
- flush_d  out  1  clear the D register
- instret  out  INSTRET_WIDTH  retired-instruction count

## Operation
- Bubble: all control fields 0, rd 0, valid 0. A bubble never writes memory or the register file.
- Load-use hazard: lu = valid_e & (ResultSrcE == 2'b01) & (rdE != 0) & valid_d & ((rdE == rs1D) | (rdE == rs2D)). ResultSrcE and BranchE/JumpE are internal E-stage fields.
- Redirect: PCSrcE = valid_e & (JumpE | (BranchE & take_branch_e)).
- flush_d = PCSrcE.
- stall_d = lu & ~PCSrcE. A redirect discards D, so no stall is needed.
- E-stage register update each edge:
  - if PCSrcE | lu, load a bubble;
  - otherwise load the D bundle, with valid_e <= valid_d.
  - Invalid D inputs are loaded as a bubble: all fields gated with valid_d.
- M <= E, and W <= M, unconditionally.
- instret increments by 1 on each edge where valid_w = 1. It wraps modulo 2^INSTRET_WIDTH with no saturation.
- Reset (asynchronous, immediate): all stage registers become bubbles, instret = 0. As a result, PCSrcE, stall_d and flush_d are 0 during reset. Asserting reset mid-operation discards all in-flight instructions.

## Timing
- Stage registers are pure flops. An instruction valid in D at edge n is in E after n, in M after n+1 and in W after n+2. Its W outputs are visible for one cycle.
- PCSrcE, stall_d and flush_d are combinational from the E register, the D inputs and take_branch_e. They are valid in the same cycle, before the next edge.
- A load-use stall lasts exactly 1 cycle per hazard. After the edge, E holds a bubble, so lu drops.
- Simultaneous lu and PCSrcE: PCSrcE wins (flush_d = 1, stall_d = 0), and E gets a bubble.
- The instret increment for a retired instruction becomes visible 1 cycle after its valid_w cycle.

## Configuration
- CTRL_PIPE_MEMSTALL_EN defined:
  - the stall_m port exists;
  - while stall_m = 1, the E and M registers hold, W loads a bubble, stall_d is forced to 1, and flush_d and PCSrcE are forced to 0;
  - a pending redirect fires in the first cycle after stall_m deasserts;
  - instret does not count the inserted W bubbles.
- CTRL_PIPE_MEMSTALL_EN undefined: no stall_m port, and the stages always advance as described above.

## Structure
- Package ctrl_pkg:
  - ctrl_e_t, ctrl_m_t, ctrl_w_t packed structs;
  - constants RESULT_LOAD = 2'b01 and CTRL_E_BUBBLE / CTRL_M_BUBBLE / CTRL_W_BUBBLE.
- Sub-module ctrl_stage_reg:
  - type-parameterized flop with async reset to a bubble value;
  - hold and bubble inputs, with bubble taking priority over hold;
  - instantiated three times.
- Hazard/redirect logic and the instret counter live in control_pipe.

## Test plan
- Back-to-back ALU ops with rd = 1, 2, 3 in consecutive cycles -> rdW = 1, 2, 3 on cycles n+2, n+3, n+4; instret = 3 afterwards.
- Load to x5 (ResultSrcD = 01) followed by an add with rs1 = 5 -> stall_d = 1 for 1 cycle, one W bubble, add retires 1 cycle late.
- Load to x0 followed by a use of x0 -> no stall.
- Branch in E with take_branch_e = 1 while a load-use condition is also present -> PCSrcE = 1, flush_d = 1, stall_d = 0, next E is a bubble.
- Reset asserted with 3 valid instructions in flight -> all outputs 0 immediately, instret = 0, no write after release.
- Preset instret to all-ones, then retire one instruction -> wraps to 0.
- CTRL_PIPE_MEMSTALL_EN: stall_m held 2 cycles with a store in M -> MemWriteM held, W gets 2 bubbles, instret is unchanged during the stall.
